// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared constants for the LED pattern engine
package led_pattern_pkg;

    localparam logic [1:0] MODE_ALT_ENDS = 2'd0;
    localparam logic [1:0] MODE_ROTATE   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE   = 2'd2;
    localparam logic [1:0] MODE_BLINK    = 2'd3;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// rtl/led_pattern_gen_tick_prescaler.sv - speed-scaled step event generator
module tick_prescaler #(
    parameter int PERIOD = 33554432,
    parameter int CNT_W  = $clog2(PERIOD) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] speed,
    output logic       step
);

    localparam logic [CNT_W-1:0] PERIOD_V = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lim;
    logic             hit;

    // >= rather than == so a speed increase that strands cnt above the new limit steps at once
    always_comb begin
        lim  = PERIOD_V >> speed;
        hit  = (cnt >= (lim - ONE));
        step = en & hit;
    end

    // free-running count while enabled, wrapping to zero on each step
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            if (hit) cnt <= '0;
            else     cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - selectable LED pattern engine with shared prescaler
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int PERIOD = 33554432
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    output logic [WIDTH-1:0] led,
    output logic             tick
);

    localparam int CNT_W = $clog2(PERIOD) + 1;

    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB_ONLY = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic             step;
    logic             dir;
    logic [WIDTH-1:0] next_led;
    logic             next_dir;
    logic             one_hot;

    tick_prescaler #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .speed (speed),
        .step  (step)
    );

    // next pattern value; every mode recovers from whatever a previous mode left behind
    always_comb begin
        next_led = led;
        next_dir = dir;
        one_hot  = (led != '0) && ((led & (led - LSB_ONLY)) == '0);
        case (mode)
            MODE_ALT_ENDS: begin
                next_led = (led == MSB_ONLY) ? LSB_ONLY : MSB_ONLY;
            end
            MODE_ROTATE: begin
                if (led == '0) next_led = MSB_ONLY;
                else           next_led = {led[0], led[WIDTH-1:1]};
            end
            MODE_BOUNCE: begin
                if (!one_hot) begin
                    next_led = MSB_ONLY;
                    next_dir = DIR_RIGHT;
                end else if (dir == DIR_RIGHT) begin
                    // turning at bit 0 moves straight to bit 1 so the end is not shown twice
                    if (led[0]) begin
                        next_led = led << 1;
                        next_dir = DIR_LEFT;
                    end else begin
                        next_led = led >> 1;
                    end
                end else begin
                    if (led[WIDTH-1]) begin
                        next_led = led >> 1;
                        next_dir = DIR_RIGHT;
                    end else begin
                        next_led = led << 1;
                    end
                end
            end
            default: begin
                next_led = (led == ALL_ONES) ? '0 : ALL_ONES;
            end
        endcase
    end

    // pattern state moves only on a step; tick marks the first cycle of each new value
    always_ff @(posedge clk) begin
        if (rst) begin
            led  <= MSB_ONLY;
            dir  <= DIR_RIGHT;
            tick <= 1'b0;
        end else begin
            tick <= step;
            if (step) begin
                led <= next_led;
                dir <= next_dir;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed vector bench for led_pattern_gen
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [1:0] speed = 2'd0;
    logic [7:0] led;
    logic       tick;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_led;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] speed;
        int         gap;
        logic [7:0] led;
    } vec_t;

    vec_t vecs[$];

    led_pattern_gen #(
        .WIDTH  (8),
        .PERIOD (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .speed (speed),
        .led   (led),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_check(input string nm);
        chk({nm, " led hold"}, led, model_led);
        chk({nm, " tick low"}, {7'b0, tick}, 8'h00);
    endtask

    // gap-1 quiet cycles, then the new value with tick in the gap-th cycle
    task automatic run_step(input int gap, input logic [7:0] exp, input string nm);
        for (int i = 1; i <= gap; i++) begin
            cyc();
            if (i < gap) begin
                hold_check(nm);
            end else begin
                chk({nm, " led"}, led, exp);
                chk({nm, " tick"}, {7'b0, tick}, 8'h01);
            end
        end
        model_led = exp;
    endtask

    task automatic add(input logic [1:0] m, input logic [1:0] s, input int g, input logic [7:0] l);
        vec_t v;
        v.mode = m; v.speed = s; v.gap = g; v.led = l;
        vecs.push_back(v);
    endtask

    initial begin
        // alternate-ends from reset
        add(2'd0, 2'd0, 8, 8'h01); add(2'd0, 2'd0, 8, 8'h80);
        // rotate right one full lap
        add(2'd1, 2'd0, 8, 8'h40); add(2'd1, 2'd0, 8, 8'h20); add(2'd1, 2'd0, 8, 8'h10);
        add(2'd1, 2'd0, 8, 8'h08); add(2'd1, 2'd0, 8, 8'h04); add(2'd1, 2'd0, 8, 8'h02);
        add(2'd1, 2'd0, 8, 8'h01); add(2'd1, 2'd0, 8, 8'h80);
        // bounce at speed 2, no repeated value at either end
        add(2'd2, 2'd2, 2, 8'h40); add(2'd2, 2'd2, 2, 8'h20); add(2'd2, 2'd2, 2, 8'h10);
        add(2'd2, 2'd2, 2, 8'h08); add(2'd2, 2'd2, 2, 8'h04); add(2'd2, 2'd2, 2, 8'h02);
        add(2'd2, 2'd2, 2, 8'h01); add(2'd2, 2'd2, 2, 8'h02); add(2'd2, 2'd2, 2, 8'h04);
        add(2'd2, 2'd2, 2, 8'h08); add(2'd2, 2'd2, 2, 8'h10); add(2'd2, 2'd2, 2, 8'h20);
        add(2'd2, 2'd2, 2, 8'h40); add(2'd2, 2'd2, 2, 8'h80); add(2'd2, 2'd2, 2, 8'h40);
        // blink at speed 1
        add(2'd3, 2'd1, 4, 8'hFF); add(2'd3, 2'd1, 4, 8'h00); add(2'd3, 2'd1, 4, 8'hFF);
        // bounce entry from non-one-hot restarts at MSB heading right
        add(2'd2, 2'd2, 2, 8'h80); add(2'd2, 2'd2, 2, 8'h40);

        rst = 1'b1;
        cyc();
        cyc();
        chk("reset led", led, 8'h80);
        chk("reset tick", {7'b0, tick}, 8'h00);
        model_led = 8'h80;
        rst = 1'b0;
        en = 1'b1;

        foreach (vecs[i]) begin
            mode = vecs[i].mode;
            speed = vecs[i].speed;
            run_step(vecs[i].gap, vecs[i].led, $sformatf("vec%0d", i));
        end

        // speed 0 -> 3 with cnt stranded at 5: immediate step, then one per cycle
        mode = 2'd1;
        speed = 2'd0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            hold_check("pre speedup");
        end
        speed = 2'd3;
        run_step(1, 8'h20, "speedup first");
        run_step(1, 8'h10, "speedup second");
        run_step(1, 8'h08, "speedup third");
        speed = 2'd0;

        // enable dropped at cnt=3 freezes everything for 20 cycles
        for (int i = 0; i < 3; i++) begin
            cyc();
            hold_check("pre freeze");
        end
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            hold_check("frozen");
        end
        en = 1'b1;
        run_step(5, 8'h04, "resume");

        // alt-ends from a non-canonical value loads MSB-only
        mode = 2'd0;
        run_step(8, 8'h80, "alt from 04");

        // reset mid-count restarts the prescaler from zero
        for (int i = 0; i < 3; i++) begin
            cyc();
            hold_check("pre reset");
        end
        rst = 1'b1;
        cyc();
        chk("midreset led", led, 8'h80);
        chk("midreset tick", {7'b0, tick}, 8'h00);
        rst = 1'b0;
        model_led = 8'h80;
        run_step(8, 8'h01, "post reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern engine driving a WIDTH-bit LED bank from the board clock. A shared prescaler produces step events, and the selected pattern advances one step per event. The selectable patterns are:
- alternate-ends (MSB/LSB swap)
- rotate
- bounce (Knight Rider)
- blink-all

The block sits at top level between board switches (mode/speed/enable) and the led output pins.

Parameters:
WIDTH, 16, number of LEDs driven (must be >= 2)
PERIOD, 33554432, base step period in clk cycles at speed=0 (must be >= 8)
CNT_W, $clog2(PERIOD)+1, prescaler counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
en  input  1  run enable; low freezes prescaler and pattern
mode  input  2  pattern select: 0 ALT_ENDS, 1 ROTATE, 2 BOUNCE, 3 BLINK
speed  input  2  rate select; step limit = PERIOD >> speed
led  output  WIDTH  registered LED pattern
tick  output  1  one-cycle pulse, high in the cycle the new led value first appears

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, and dominates en/mode/speed.
- Reset values: led = 1 << (WIDTH-1) (MSB only); prescaler cnt = 0; dir = RIGHT (toward LSB); tick = 0.
- Prescaler:
  - lim = PERIOD >> speed, computed combinationally.
  - When en=1: if cnt >= lim-1, then cnt <= 0 and step=1; else cnt <= cnt+1 and step=0.
  - The >= compare means a speed increase that leaves cnt above the new limit steps on the next enabled cycle. There is no stall.
  - When en=0: cnt holds, step=0.
- Latency: step and the led update occur on the same edge. tick is registered from step, so it is high exactly while the new pattern is first visible.
- Step interval is exactly lim enabled cycles between led updates.
- Pattern update on step, by mode:
  - ALT_ENDS: if led == MSB-only, load LSB-only. Otherwise load MSB-only. This covers any non-canonical led after a mode change.
  - ROTATE: led <= {led[0], led[WIDTH-1:1]} (rotate right, LSB wraps to MSB). If led == 0, load MSB-only.
  - BOUNCE:
    - If led is not one-hot, load MSB-only and set dir=RIGHT.
    - dir=RIGHT: shift right. On reaching bit 0, the next step sets dir=LEFT and moves to bit 1 in the same step. No double dwell at the ends.
    - At bit WIDTH-1, reverse symmetrically.
  - BLINK: if led is all-ones, load all-zeros. Otherwise load all-ones.
- Mode changes take effect at the next step only. They do not reset cnt or tick, and led never changes between steps.
- dir is used only in BOUNCE. It holds its value in other modes, but is reset by the non-one-hot entry rule.
- Reset asserted mid-count or mid-pattern: the next edge applies reset values and tick=0; counting restarts from 0 after release.
- Widths: all led arithmetic is WIDTH bits. cnt is CNT_W bits and never exceeds PERIOD-1.

Decomposition:
- Package led_pattern_pkg holds:
  - mode constants MODE_ALT_ENDS=2'd0, MODE_ROTATE=2'd1, MODE_BOUNCE=2'd2, MODE_BLINK=2'd3
  - direction constants DIR_RIGHT=1'b0, DIR_LEFT=1'b1
- Sub-module tick_prescaler (params PERIOD, CNT_W; ports clk, rst, en, speed, step) owns cnt and the >= compare.
- led_pattern_gen instantiates tick_prescaler and owns led, dir, tick and the next-pattern logic.

Test Plan (WIDTH=8, PERIOD=8):
1. rst 2 cycles, then en=1, mode=0, speed=0 -> led=8'h80 after reset. The first step comes 8 cycles after rst release: led=8'h01 with a 1-cycle tick; 8 cycles later led=8'h80.
2. mode=1 -> led steps 80,40,20,10,08,04,02,01,80 every 8 cycles, with exactly one tick per step.
3. mode=2 from 8'h80 -> 80,40,...,02,01,02,04,...,80,40. Check no repeated value at either end. Forcing entry in mode=2 from BLINK's 8'hFF loads 8'h80.
4. speed=2 -> steps every 2 cycles. Switching speed 0->3 while cnt=5 -> step on the next enabled cycle (lim=1), then a step every cycle.
5. Drop en for 20 cycles when cnt=3 -> led, cnt and dir frozen, tick=0. After re-enable, the next step comes after exactly 5 more enabled cycles.
6. mode=3 from 8'h80 -> FF, 00, FF. Assert rst for 1 cycle mid-count with en=1 -> next cycle led=8'h80 and tick=0; the first step follows 8 cycles after release.
